// File: rtl/pipelined_divider_if.sv
// Operand/result handshake bundle for pipelined_divider.
// The divider connects through the slave modport; the producer/consumer side uses master.
interface pipelined_divider_if #(
    parameter int N     = 16,
    parameter int M     = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [N-1:0]     in_dividend;
    logic [M-1:0]     in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_quotient;
    logic [M-1:0]     out_remainder;
    logic             out_dbz;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_dbz, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_dbz, out_ovf, out_tag
    );
endinterface

// File: rtl/pipelined_divider.sv
// Fully pipelined restoring divider: prep stage, N one-bit step stages, fix/result stage.
// The whole pipe advances together and freezes while the result is held.
module pipelined_divider #(
    parameter int N         = 16,
    parameter int M         = 8,
    parameter int TAG_W     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipelined_divider_if.slave bus
);
    logic             adv_s;
    logic             sgn_s;
    logic             dneg_s;
    logic             vneg_s;
    logic             dbz_s;
    logic             ovf_s;
    logic [N-1:0]     dabs_s;
    logic [M-1:0]     vabs_s;

    // Index 0 is the prep stage; index k holds the state after step k.
    logic             v_q    [0:N];
    logic             v_d    [0:N];
    logic [M-1:0]     rem_q  [0:N];
    logic [M-1:0]     rem_d  [0:N];
    logic [N-1:0]     work_q [0:N];
    logic [N-1:0]     work_d [0:N];
    logic [M-1:0]     dvs_q  [0:N-1];
    logic [M-1:0]     dvs_d  [0:N-1];
    logic             qneg_q [0:N];
    logic             qneg_d [0:N];
    logic             rneg_q [0:N];
    logic             rneg_d [0:N];
    logic             dbz_q  [0:N];
    logic             dbz_d  [0:N];
    logic             ovf_q  [0:N];
    logic             ovf_d  [0:N];
    logic [M-1:0]     lo_q   [0:N];
    logic [M-1:0]     lo_d   [0:N];
    logic [TAG_W-1:0] tag_q  [0:N];
    logic [TAG_W-1:0] tag_d  [0:N];

    logic [M:0]       part_s [1:N];
    logic [M-1:0]     diff_s [1:N];
    logic             take_s [1:N];

    logic [N-1:0]     fix_quo_s;
    logic [M-1:0]     fix_rem_s;

    logic             res_valid_q, res_valid_d;
    logic [N-1:0]     res_quo_q,   res_quo_d;
    logic [M-1:0]     res_rem_q,   res_rem_d;
    logic             res_dbz_q,   res_dbz_d;
    logic             res_ovf_q,   res_ovf_d;
    logic [TAG_W-1:0] res_tag_q,   res_tag_d;

    assign adv_s = !(res_valid_q && !bus.out_ready);

    // Operand preparation: magnitudes, signs and special-case detection.
    always_comb begin
        sgn_s  = bus.in_signed & SIGNED_EN;
        dneg_s = sgn_s & bus.in_dividend[N-1];
        vneg_s = sgn_s & bus.in_divisor[M-1];
        dabs_s = dneg_s ? (-bus.in_dividend) : bus.in_dividend;
        vabs_s = vneg_s ? (-bus.in_divisor) : bus.in_divisor;
        dbz_s  = (bus.in_divisor == {M{1'b0}});
        ovf_s  = !dbz_s && sgn_s
                 && (bus.in_dividend == {1'b1, {(N-1){1'b0}}})
                 && (bus.in_divisor == {M{1'b1}});
    end

    // One restoring step per stage: shift in the next dividend bit, compare, subtract.
    always_comb begin
        for (int k = 1; k <= N; k++) begin
            part_s[k] = {rem_q[k-1], work_q[k-1][N-1]};
            take_s[k] = (part_s[k] >= {1'b0, dvs_q[k-1]});
            diff_s[k] = part_s[k][M-1:0] - dvs_q[k-1];
        end
    end

    // Sign correction and special-case override feeding the result register.
    always_comb begin
        if (dbz_q[N]) begin
            fix_quo_s = {N{1'b1}};
            fix_rem_s = lo_q[N];
        end else if (ovf_q[N]) begin
            fix_quo_s = {1'b1, {(N-1){1'b0}}};
            fix_rem_s = {M{1'b0}};
        end else begin
            fix_quo_s = qneg_q[N] ? (-work_q[N]) : work_q[N];
            fix_rem_s = rneg_q[N] ? (-rem_q[N]) : rem_q[N];
        end
    end

    // Next-state for every stage: hold by default, shift when the pipe advances.
    always_comb begin
        for (int k = 0; k <= N; k++) begin
            v_d[k]    = v_q[k];
            rem_d[k]  = rem_q[k];
            work_d[k] = work_q[k];
            qneg_d[k] = qneg_q[k];
            rneg_d[k] = rneg_q[k];
            dbz_d[k]  = dbz_q[k];
            ovf_d[k]  = ovf_q[k];
            lo_d[k]   = lo_q[k];
            tag_d[k]  = tag_q[k];
        end
        for (int k = 0; k < N; k++) begin
            dvs_d[k] = dvs_q[k];
        end
        res_valid_d = res_valid_q;
        res_quo_d   = res_quo_q;
        res_rem_d   = res_rem_q;
        res_dbz_d   = res_dbz_q;
        res_ovf_d   = res_ovf_q;
        res_tag_d   = res_tag_q;

        if (flush) begin
            for (int k = 0; k <= N; k++) begin
                v_d[k] = 1'b0;
            end
            res_valid_d = 1'b0;
        end else if (adv_s) begin
            v_d[0]    = bus.in_valid;
            rem_d[0]  = {M{1'b0}};
            work_d[0] = dabs_s;
            dvs_d[0]  = vabs_s;
            qneg_d[0] = dneg_s ^ vneg_s;
            rneg_d[0] = dneg_s;
            dbz_d[0]  = dbz_s;
            ovf_d[0]  = ovf_s;
            lo_d[0]   = bus.in_dividend[M-1:0];
            tag_d[0]  = bus.in_tag;
            for (int k = 1; k <= N; k++) begin
                v_d[k]    = v_q[k-1];
                rem_d[k]  = take_s[k] ? diff_s[k] : part_s[k][M-1:0];
                work_d[k] = {work_q[k-1][N-2:0], take_s[k]};
                qneg_d[k] = qneg_q[k-1];
                rneg_d[k] = rneg_q[k-1];
                dbz_d[k]  = dbz_q[k-1];
                ovf_d[k]  = ovf_q[k-1];
                lo_d[k]   = lo_q[k-1];
                tag_d[k]  = tag_q[k-1];
            end
            for (int k = 1; k < N; k++) begin
                dvs_d[k] = dvs_q[k-1];
            end
            res_valid_d = v_q[N];
            res_quo_d   = fix_quo_s;
            res_rem_d   = fix_rem_s;
            res_dbz_d   = dbz_q[N];
            res_ovf_d   = ovf_q[N] & ~dbz_q[N];
            res_tag_d   = tag_q[N];
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers for all stages and the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= N; k++) begin
                v_q[k]    <= 1'b0;
                rem_q[k]  <= {M{1'b0}};
                work_q[k] <= {N{1'b0}};
                qneg_q[k] <= 1'b0;
                rneg_q[k] <= 1'b0;
                dbz_q[k]  <= 1'b0;
                ovf_q[k]  <= 1'b0;
                lo_q[k]   <= {M{1'b0}};
                tag_q[k]  <= {TAG_W{1'b0}};
            end
            for (int k = 0; k < N; k++) begin
                dvs_q[k] <= {M{1'b0}};
            end
            res_valid_q <= 1'b0;
            res_quo_q   <= {N{1'b0}};
            res_rem_q   <= {M{1'b0}};
            res_dbz_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_tag_q   <= {TAG_W{1'b0}};
        end else begin
            for (int k = 0; k <= N; k++) begin
                v_q[k]    <= v_d[k];
                rem_q[k]  <= rem_d[k];
                work_q[k] <= work_d[k];
                qneg_q[k] <= qneg_d[k];
                rneg_q[k] <= rneg_d[k];
                dbz_q[k]  <= dbz_d[k];
                ovf_q[k]  <= ovf_d[k];
                lo_q[k]   <= lo_d[k];
                tag_q[k]  <= tag_d[k];
            end
            for (int k = 0; k < N; k++) begin
                dvs_q[k] <= dvs_d[k];
            end
            res_valid_q <= res_valid_d;
            res_quo_q   <= res_quo_d;
            res_rem_q   <= res_rem_d;
            res_dbz_q   <= res_dbz_d;
            res_ovf_q   <= res_ovf_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign bus.in_ready      = adv_s;
    assign bus.out_valid     = res_valid_q;
    assign bus.out_quotient  = res_quo_q;
    assign bus.out_remainder = res_rem_q;
    assign bus.out_dbz       = res_dbz_q;
    assign bus.out_ovf       = res_ovf_q;
    assign bus.out_tag       = res_tag_q;
endmodule

// File: tb/tb_pipelined_divider.sv
// Bench for pipelined_divider: integer-arithmetic reference model with an in-order
// scoreboard checked every cycle, plus directed literal cases, flush and reset scenarios.
module tb_pipelined_divider;
    localparam int N     = 16;
    localparam int M     = 8;
    localparam int TAG_W = 4;
    localparam int LAT   = N + 2;

    typedef struct packed {
        logic [N-1:0]     q;
        logic [M-1:0]     r;
        logic             dbz;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    pipelined_divider_if #(.N(N), .M(M), .TAG_W(TAG_W)) bus ();

    pipelined_divider #(.N(N), .M(M), .TAG_W(TAG_W), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    logic prev_stall  = 1'b0;
    res_t prev_out;
    logic rnd_on;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer division; SV truncates toward zero and % follows the dividend.
    function automatic res_t model(input logic sgn, input logic [N-1:0] a,
                                   input logic [M-1:0] b, input logic [TAG_W-1:0] t);
        res_t   e;
        longint sa, sb, q, r;
        e.tag = t;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a[M-1:0];
            e.dbz = 1'b1;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            q     = sa / sb;
            r     = sa % sb;
            e.q   = q[N-1:0];
            e.r   = r[M-1:0];
            e.ovf = sgn && (sa == -(64'sd1 <<< (N-1))) && (sb == -64'sd1);
        end
        return e;
    endfunction

    function automatic res_t cur_out();
        res_t c;
        c.q   = bus.out_quotient;
        c.r   = bus.out_remainder;
        c.dbz = bus.out_dbz;
        c.ovf = bus.out_ovf;
        c.tag = bus.out_tag;
        return c;
    endfunction

    // Scoreboard: compares outputs on the falling edge, then records this cycle's transfer.
    always @(negedge clk) begin
        res_t cur;
        cur = cur_out();
        if (reset) begin
            check("reset_outputs", {bus.out_valid, cur}, 64'd0);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {bus.out_valid, cur}, {1'b1, prev_out});
            if (bus.out_valid) begin
                check("result_expected", (exp_q.size() == 0) ? 0 : 1, 1);
                if (exp_q.size() > 0) begin
                    check("result", cur, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !flush;
            prev_out   = cur;
            if (flush)
                exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_signed, bus.in_dividend, bus.in_divisor, bus.in_tag));
        end
    end

    // Present one operation (called just after a rising edge) and wait for its transfer.
    task automatic send(input logic sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic [TAG_W-1:0] t);
        int waited = 0;
        bus.in_valid    = 1'b1;
        bus.in_signed   = sgn;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.in_tag      = t;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", (waited >= 200) ? 1 : 0, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single operation into an idle pipe with out_ready high: latency and literal result.
    task automatic directed(input string name, input logic sgn, input logic [N-1:0] a,
                            input logic [M-1:0] b, input logic [TAG_W-1:0] t, input res_t req);
        int cnt = 0;
        bus.in_valid    = 1'b1;
        bus.in_signed   = sgn;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.in_tag      = t;
        @(negedge clk);
        check({name, "_ready"}, bus.in_ready, 1);
        do begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            cnt++;
        end while (!bus.out_valid && cnt < 100);
        check({name, "_latency"}, cnt, LAT);
        check(name, cur_out(), req);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end

    initial begin
        int wait_cnt;
        reset           = 1'b1;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_signed   = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b1;
        rnd_on          = 1'b0;

        // Pin the reference model to hand-computed results.
        check("model_u1000_7",    model(1'b0, 16'd1000,  8'd7,    4'd3), {16'h008E, 8'h06, 1'b0, 1'b0, 4'd3});
        check("model_sn1000_7",   model(1'b1, 16'hFC18,  8'd7,    4'd0), {16'hFF72, 8'hFA, 1'b0, 1'b0, 4'd0});
        check("model_s1000_n7",   model(1'b1, 16'd1000,  8'hF9,   4'd0), {16'hFF72, 8'h06, 1'b0, 1'b0, 4'd0});
        check("model_ovf",        model(1'b1, 16'h8000,  8'hFF,   4'd0), {16'h8000, 8'h00, 1'b0, 1'b1, 4'd0});
        check("model_dbz",        model(1'b0, 16'd1234,  8'd0,    4'd0), {16'hFFFF, 8'hD2, 1'b1, 1'b0, 4'd0});
        check("model_u8000_ff",   model(1'b0, 16'h8000,  8'hFF,   4'd0), {16'd128,  8'd128, 1'b0, 1'b0, 4'd0});

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", bus.in_ready, 1);
        check("post_reset_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        directed("u1000_7",    1'b0, 16'd1000, 8'd7,  4'd3, {16'h008E, 8'h06, 1'b0, 1'b0, 4'd3});
        directed("sn1000_7",   1'b1, 16'hFC18, 8'd7,  4'd5, {16'hFF72, 8'hFA, 1'b0, 1'b0, 4'd5});
        directed("s1000_n7",   1'b1, 16'd1000, 8'hF9, 4'd6, {16'hFF72, 8'h06, 1'b0, 1'b0, 4'd6});
        directed("sn1000_n7",  1'b1, 16'hFC18, 8'hF9, 4'd7, {16'h008E, 8'hFA, 1'b0, 1'b0, 4'd7});
        directed("dbz_1234",   1'b0, 16'd1234, 8'd0,  4'd8, {16'hFFFF, 8'hD2, 1'b1, 1'b0, 4'd8});
        directed("s_ovf",      1'b1, 16'h8000, 8'hFF, 4'd9, {16'h8000, 8'h00, 1'b0, 1'b1, 4'd9});
        directed("u8000_ff",   1'b0, 16'h8000, 8'hFF, 4'hA, {16'd128,  8'd128, 1'b0, 1'b0, 4'hA});

        // Random stream with pseudo-random backpressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    logic [N-1:0] a;
                    logic [M-1:0] b;
                    logic         s;
                    int           sel;
                    a   = N'($urandom);
                    b   = M'($urandom);
                    s   = 1'($urandom_range(0, 1));
                    sel = $urandom_range(0, 9);
                    if (sel == 0) b = '0;
                    if (sel == 1) begin
                        s = 1'b1;
                        a = 16'h8000;
                        b = 8'hFF;
                    end
                    send(s, a, b, TAG_W'(i));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("stream_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Flush with five operations in flight; in_valid during the flush is ignored.
        for (int i = 0; i < 5; i++) send(1'b0, N'($urandom), 8'd3, TAG_W'(i));
        bus.in_valid    = 1'b1;
        bus.in_dividend = 16'd77;
        bus.in_divisor  = 8'd5;
        flush           = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        directed("after_flush", 1'b0, 16'd500, 8'd9, 4'hC, {16'd55, 8'd5, 1'b0, 1'b0, 4'hC});

        // Reset in the middle of a stream.
        for (int i = 0; i < 6; i++) send(1'b1, N'($urandom), M'($urandom_range(1, 255)), TAG_W'(i));
        reset = 1'b1;
        #1;
        check("reset_immediate", {bus.out_valid, cur_out()}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        directed("after_reset", 1'b1, 16'hFF9C, 8'd7, 4'hD, {16'hFFF2, 8'hFE, 1'b0, 1'b0, 4'hD});

        repeat (LAT + 2) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
